// File: rtl/tonomat_pkg.sv
// Shared types and constants for the change dispenser.
//   state_e : payout FSM states
//   coin_e  : which hopper the current pulse belongs to
//   VAL_R5 / VAL_R1 : coin face values in lei
package tonomat_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SELECT = 3'd1,
    PULSE  = 3'd2,
    GAP    = 3'd3,
    DONE   = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    COIN_NONE = 2'd0,
    COIN_R5   = 2'd1,
    COIN_R1   = 2'd2
  } coin_e;

  localparam int VAL_R5 = 5;
  localparam int VAL_R1 = 1;

endpackage

// File: rtl/rest_dispenser_if.sv
// Change-request / hopper interface between the automat core and the
// dispenser.
//   master : automat side (drives req_valid, req_amount, refill)
//   slave  : dispenser side (drives req_ready, R5, R1, busy, done,
//            shortfall, inv5, inv1)
interface rest_dispenser_if #(
  parameter int AMT_W = 5,
  parameter int INV_W = 8
);
  logic             req_valid;
  logic [AMT_W-1:0] req_amount;
  logic             req_ready;
  logic             R5;
  logic             R1;
  logic             busy;
  logic             done;
  logic [AMT_W-1:0] shortfall;
  logic             refill;
  logic [INV_W-1:0] inv5;
  logic [INV_W-1:0] inv1;

  modport master (
    output req_valid, req_amount, refill,
    input  req_ready, R5, R1, busy, done, shortfall, inv5, inv1
  );

  modport slave (
    input  req_valid, req_amount, refill,
    output req_ready, R5, R1, busy, done, shortfall, inv5, inv1
  );
endinterface

// File: rtl/hopper_counter.sv
// Coin inventory for one hopper.
//   clk, reset : clock, async active-high reset (reset loads INIT)
//   load_i     : reload to INIT (hopper refilled)
//   dec_i      : one coin ejected
//   count_o    : coins remaining
//   empty_o    : count_o == 0
module hopper_counter #(
  parameter int W    = 8,
  parameter int INIT = 20
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic         dec_i,
  output logic [W-1:0] count_o,
  output logic         empty_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Guarding the decrement here keeps the count from wrapping even if the
  // caller asks for a coin from an empty hopper.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = W'(INIT);
    else if (dec_i && (cnt_q != '0))
      cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= W'(INIT);
    else       cnt_q <= cnt_d;
  end

  assign count_o = cnt_q;
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/rest_dispenser.sv
// Change payout: accepts an amount over valid/ready and ejects coins one
// pulse at a time, 5-lei coins first, then 1-lei coins, while hoppers last.
//   clk, reset : clock, async active-high reset
//   bus        : slave side of rest_dispenser_if (request handshake, R5/R1
//                pulses, busy/done, shortfall, refill, inventories)
//
// state  | meaning
// IDLE   | waiting for a request; refill accepted here
// SELECT | pick next coin from rem and inventory, or finish
// PULSE  | chosen hopper output high for PULSE_CYC cycles
// GAP    | both outputs low for GAP_CYC cycles
// DONE   | one-cycle done pulse, unpaid remainder latched to shortfall
module rest_dispenser
  import tonomat_pkg::*;
#(
  parameter int AMT_W     = 5,
  parameter int INV_W     = 8,
  parameter int PULSE_CYC = 2,
  parameter int GAP_CYC   = 1,
  parameter int INV5_INIT = 20,
  parameter int INV1_INIT = 20
) (
  input logic              clk,
  input logic              reset,
  rest_dispenser_if.slave  bus
);

  localparam int MAX_CYC = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  // Timer is a down-counter: loaded with length-1, phase ends at zero.
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_CYC - 1);
  localparam logic [AMT_W-1:0] AMT_R5   = AMT_W'(VAL_R5);
  localparam logic [AMT_W-1:0] AMT_R1   = AMT_W'(VAL_R1);

  state_e           state_q, state_d;
  coin_e            coin_q, coin_d;
  logic [AMT_W-1:0] rem_q, rem_d;
  logic [AMT_W-1:0] shortfall_q, shortfall_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dec5, dec1;
  logic             empty5, empty1;
  logic             load_inv;
  logic [INV_W-1:0] inv5_cnt, inv1_cnt;

  // Refill only while idle; it lands on the same edge as an accepted
  // request, so the first SELECT already sees full hoppers.
  assign load_inv = bus.refill && (state_q == IDLE);

  hopper_counter #(.W(INV_W), .INIT(INV5_INIT)) u_hopper5 (
    .clk     (clk),
    .reset   (reset),
    .load_i  (load_inv),
    .dec_i   (dec5),
    .count_o (inv5_cnt),
    .empty_o (empty5)
  );

  hopper_counter #(.W(INV_W), .INIT(INV1_INIT)) u_hopper1 (
    .clk     (clk),
    .reset   (reset),
    .load_i  (load_inv),
    .dec_i   (dec1),
    .count_o (inv1_cnt),
    .empty_o (empty1)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      coin_q      <= COIN_NONE;
      rem_q       <= '0;
      shortfall_q <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      coin_q      <= coin_d;
      rem_q       <= rem_d;
      shortfall_q <= shortfall_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    coin_d      = coin_q;
    rem_d       = rem_q;
    shortfall_d = shortfall_q;
    cnt_d       = cnt_q;
    dec5        = 1'b0;
    dec1        = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          rem_d   = bus.req_amount;
          state_d = SELECT;
        end
      end

      // An empty R5 hopper falls through to the R1 branch, so a large
      // remainder is paid entirely in 1-lei coins.
      SELECT: begin
        if ((rem_q >= AMT_R5) && !empty5) begin
          coin_d  = COIN_R5;
          rem_d   = rem_q - AMT_R5;
          dec5    = 1'b1;
          cnt_d   = PULSE_LD;
          state_d = PULSE;
        end else if ((rem_q >= AMT_R1) && !empty1) begin
          coin_d  = COIN_R1;
          rem_d   = rem_q - AMT_R1;
          dec1    = 1'b1;
          cnt_d   = PULSE_LD;
          state_d = PULSE;
        end else begin
          coin_d  = COIN_NONE;
          state_d = DONE;
        end
      end

      PULSE: begin
        if (cnt_q == '0) begin
          cnt_d   = GAP_LD;
          state_d = GAP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      GAP: begin
        if (cnt_q == '0) state_d = SELECT;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end

      DONE: begin
        shortfall_d = rem_q;
        coin_d      = COIN_NONE;
        state_d     = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // Hopper pulses come only from registers, so reset clears them at once.
  assign bus.R5        = (state_q == PULSE) && (coin_q == COIN_R5);
  assign bus.R1        = (state_q == PULSE) && (coin_q == COIN_R1);
  assign bus.req_ready = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);
  assign bus.shortfall = shortfall_q;
  assign bus.inv5      = inv5_cnt;
  assign bus.inv1      = inv1_cnt;

endmodule

// File: tb/tb_rest_dispenser.sv
// Randomised and directed bench for rest_dispenser against a coin-count
// reference model (closed-form greedy payout and pulse schedule).
module tb_rest_dispenser;

  localparam int P       = 2;
  localparam int G       = 1;
  localparam int CC      = 1 + P + G;
  localparam int INV5_I  = 20;
  localparam int INV1_I  = 20;

  logic clk;
  logic reset;

  rest_dispenser_if #(.AMT_W(5), .INV_W(8)) bus ();

  rest_dispenser #(
    .AMT_W(5), .INV_W(8), .PULSE_CYC(P), .GAP_CYC(G),
    .INV5_INIT(INV5_I), .INV1_INIT(INV1_I)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int m_inv5, m_inv1, m_short;

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_idle();
    check_val("shortfall", 32'(bus.shortfall), m_short);
    check_val("inv5", 32'(bus.inv5), m_inv5);
    check_val("inv1", 32'(bus.inv1), m_inv1);
    check_val("idle_busy", 32'(bus.busy), 0);
    check_val("idle_done", 32'(bus.done), 0);
    check_val("idle_ready", 32'(bus.req_ready), 1);
    check_val("idle_r5r1", 32'({bus.R5, bus.R1}), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset          = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_amount = '0;
    bus.refill     = 1'b0;
    m_inv5  = INV5_I;
    m_inv1  = INV1_I;
    m_short = 0;
    #1;
    check_idle();
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One full request. rf_same: refill in the accept cycle.
  // rf_busy: refill pulse while payout is in progress (must be ignored).
  task automatic run_req(input int amt, input bit rf_same, input bit rf_busy);
    int n5, n1, r, sf, done_c, k, ph;
    bit e5, e1;
    if (rf_same) begin
      m_inv5 = INV5_I;
      m_inv1 = INV1_I;
    end
    n5 = amt / 5;
    if (n5 > m_inv5) n5 = m_inv5;
    r  = amt - 5 * n5;
    n1 = (r < m_inv1) ? r : m_inv1;
    sf = r - n1;
    done_c = 2 + (n5 + n1) * CC;

    @(negedge clk);
    check_val("ready_pre", 32'(bus.req_ready), 1);
    bus.req_valid  = 1'b1;
    bus.req_amount = 5'(amt);
    bus.refill     = rf_same;
    @(posedge clk);
    for (int c = 1; c <= done_c; c++) begin
      @(negedge clk);
      if (c == 1) begin
        bus.req_valid = 1'b0;
        bus.refill    = 1'b0;
      end
      if (rf_busy && c == 3) bus.refill = 1'b1;
      if (c == 4) bus.refill = 1'b0;
      k  = (c - 2) / CC;
      ph = (c - 2) % CC;
      e5 = (c >= 2) && (k < n5) && (ph < P);
      e1 = (c >= 2) && (k >= n5) && (k < n5 + n1) && (ph < P);
      check_val("r5", 32'(bus.R5), 32'(e5));
      check_val("r1", 32'(bus.R1), 32'(e1));
      check_val("excl", 32'(bus.R5 & bus.R1), 0);
      check_val("done", 32'(bus.done), 32'(c == done_c));
      check_val("busy", 32'(bus.busy), 1);
    end
    bus.refill = 1'b0;
    m_inv5 -= n5;
    m_inv1 -= n1;
    m_short = sf;
    @(negedge clk);
    check_idle();
  endtask

  initial begin
    int amt;
    int guard;
    reset          = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_amount = '0;
    bus.refill     = 1'b0;
    m_inv5  = INV5_I;
    m_inv1  = INV1_I;
    m_short = 0;
    repeat (2) @(negedge clk);
    check_idle();
    reset = 1'b0;

    // 7 lei: R5 c2-c3, R1 c6-c7 and c10-c11, done c14
    run_req(7, 1'b0, 1'b0);
    check_val("inv5_after7", 32'(bus.inv5), 19);
    check_val("inv1_after7", 32'(bus.inv1), 18);
    run_req(0, 1'b0, 1'b0);

    // R5 hopper exhausted: 6 lei paid in six R1 coins
    do_reset();
    for (int i = 0; i < 4; i++) run_req(25, 1'b0, 1'b0);
    run_req(6, 1'b0, 1'b0);
    // leave two R1 coins, then 7 lei pays 2 with shortfall 5
    run_req(12, 1'b0, 1'b0);
    run_req(7, 1'b0, 1'b0);
    check_val("short5", 32'(bus.shortfall), 5);
    check_val("inv1_zero", 32'(bus.inv1), 0);

    // randomised traffic with occasional refills
    do_reset();
    for (int i = 0; i < 30; i++) begin
      amt = int'($urandom_range(0, 31));
      run_req(amt, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
    end

    // drain both hoppers, then refill together with a 5-lei request
    guard = 0;
    while ((m_inv5 > 0 || m_inv1 > 0) && guard < 20) begin
      run_req(31, 1'b0, 1'b0);
      guard++;
    end
    run_req(3, 1'b0, 1'b0);
    run_req(5, 1'b1, 1'b0);
    check_val("inv5_refill", 32'(bus.inv5), 19);
    run_req(12, 1'b0, 1'b1);

    // reset in the middle of a 10-lei payout
    do_reset();
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_amount = 5'd10;
    @(posedge clk);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (c == 1) bus.req_valid = 1'b0;
    end
    check_val("mid_r5", 32'(bus.R5), 1);
    reset = 1'b1;
    #1;
    check_val("rst_r5", 32'(bus.R5), 0);
    check_val("rst_inv5", 32'(bus.inv5), INV5_I);
    check_val("rst_ready", 32'(bus.req_ready), 1);
    m_inv5  = INV5_I;
    m_inv1  = INV1_I;
    m_short = 0;
    @(negedge clk);
    reset = 1'b0;
    run_req(1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
